// File: rtl/issue_dispatch.sv
// Dual in-order issue stage: picks 0/1/2 of the two oldest buffered instructions and merges regfile data.
// Latency: 1 cycle from issue decision to o_ex_*. o_usingNUM returns to the buffer combinationally.
// Backpressure: stall_DCache freezes EX regs and scoreboard and forces zero issue; flush_BR clears both.
package issue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  inst_type;
        logic        rf_we;
        logic [4:0]  rf_rd;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic        mem_we;
        logic [31:0] rf_rdata1;
        logic [31:0] rf_rdata2;
    } pc_set_t;
endpackage

module issue_dispatch
    import issue_pkg::*;
#(
    parameter int         LOAD_LAT = 2,
    parameter logic [4:0] TYPE_MEM = 5'd3,
    parameter logic [4:0] TYPE_BR  = 5'd2,
    parameter logic [4:0] TYPE_MDV = 5'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_set_t     i_set_a,
    input  pc_set_t     i_set_b,
    input  logic [1:0]  i_is_valid,
    input  logic [31:0] i_a_rdata1,
    input  logic [31:0] i_a_rdata2,
    input  logic [31:0] i_b_rdata1,
    input  logic [31:0] i_b_rdata2,
    input  logic        flush_BR,
    input  logic        stall_DCache,
    output logic [1:0]  o_usingNUM,
    output pc_set_t     o_ex_set_a,
    output pc_set_t     o_ex_set_b,
    output logic [1:0]  o_ex_valid
);

    localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    logic [CW-1:0] cnt [32];
    logic [31:0]   busy;

    logic a_src_busy, b_src_busy;
    logic raw, waw, a_br, both_mem, both_mdv;
    logic issue_a, issue_b;
    logic ld_vld;
    logic [4:0] ld_rd;
    pc_set_t set_a_m, set_b_m;

    function automatic logic is_load(input pc_set_t s);
        return (s.inst_type == TYPE_MEM) && !s.mem_we && s.rf_we && (s.rf_rd != 5'd0);
    endfunction

    // r0 is hardwired, so it never reports busy; unused (zero) read addresses are therefore harmless.
    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        a_src_busy = busy[i_set_a.rf_raddr1] | busy[i_set_a.rf_raddr2];
        b_src_busy = busy[i_set_b.rf_raddr1] | busy[i_set_b.rf_raddr2];
        raw        = i_set_a.rf_we && (i_set_a.rf_rd != 5'd0) &&
                     ((i_set_b.rf_raddr1 == i_set_a.rf_rd) || (i_set_b.rf_raddr2 == i_set_a.rf_rd));
        waw        = i_set_a.rf_we && i_set_b.rf_we && (i_set_a.rf_rd == i_set_b.rf_rd) &&
                     (i_set_a.rf_rd != 5'd0);
        a_br       = (i_set_a.inst_type == TYPE_BR);
        both_mem   = (i_set_a.inst_type == TYPE_MEM) && (i_set_b.inst_type == TYPE_MEM);
        both_mdv   = (i_set_a.inst_type == TYPE_MDV) && (i_set_b.inst_type == TYPE_MDV);

        issue_a = i_is_valid[1] && !flush_BR && !stall_DCache && !rst && !a_src_busy;
        issue_b = issue_a && i_is_valid[0] && !b_src_busy &&
                  !raw && !waw && !a_br && !both_mem && !both_mdv;

        o_usingNUM = issue_b ? 2'b10 : (issue_a ? 2'b01 : 2'b00);

        // Two mem ops never co-issue, so at most one load reaches the scoreboard per cycle.
        ld_vld = 1'b0;
        ld_rd  = 5'd0;
        if (issue_a && is_load(i_set_a)) begin
            ld_vld = 1'b1;
            ld_rd  = i_set_a.rf_rd;
        end else if (issue_b && is_load(i_set_b)) begin
            ld_vld = 1'b1;
            ld_rd  = i_set_b.rf_rd;
        end

        set_a_m           = i_set_a;
        set_a_m.rf_rdata1 = i_a_rdata1;
        set_a_m.rf_rdata2 = i_a_rdata2;
        set_b_m           = i_set_b;
        set_b_m.rf_rdata1 = i_b_rdata1;
        set_b_m.rf_rdata2 = i_b_rdata2;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_BR) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else if (!stall_DCache) begin
            for (int r = 0; r < 32; r++) begin
                if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
            if (ld_vld) begin
                cnt[ld_rd] <= CW'(LOAD_LAT);
            end
        end
    end

    // Non-issued slots load as bubbles; only the valid bits carry meaning.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ex_valid <= 2'b00;
            o_ex_set_a <= '0;
            o_ex_set_b <= '0;
        end else if (flush_BR) begin
            o_ex_valid <= 2'b00;
        end else if (!stall_DCache) begin
            o_ex_valid <= {issue_a, issue_b};
            o_ex_set_a <= set_a_m;
            o_ex_set_b <= set_b_m;
        end
    end

endmodule

// File: tb/tb_issue_dispatch.sv
// Self-checking bench for issue_dispatch: directed hazard scenarios plus randomized traffic
// checked against a cycles-remaining reference model of the load scoreboard and issue rules.
module tb_issue_dispatch;
    import issue_pkg::*;

    localparam int         LOAD_LAT = 2;
    localparam logic [4:0] T_ALU = 5'd1;
    localparam logic [4:0] T_BR  = 5'd2;
    localparam logic [4:0] T_MEM = 5'd3;
    localparam logic [4:0] T_MDV = 5'd4;

    logic        clk = 1'b0;
    logic        rst;
    pc_set_t     set_a, set_b;
    logic [1:0]  i_is_valid;
    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        flush_BR, stall_DCache;
    logic [1:0]  o_usingNUM;
    pc_set_t     o_ex_set_a, o_ex_set_b;
    logic [1:0]  o_ex_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    issue_dispatch dut (
        .clk          (clk),
        .rst          (rst),
        .i_set_a      (set_a),
        .i_set_b      (set_b),
        .i_is_valid   (i_is_valid),
        .i_a_rdata1   (a_rd1),
        .i_a_rdata2   (a_rd2),
        .i_b_rdata1   (b_rd1),
        .i_b_rdata2   (b_rd2),
        .flush_BR     (flush_BR),
        .stall_DCache (stall_DCache),
        .o_usingNUM   (o_usingNUM),
        .o_ex_set_a   (o_ex_set_a),
        .o_ex_set_b   (o_ex_set_b),
        .o_ex_valid   (o_ex_valid)
    );

    // Reference model: cycles a register still has to wait before it may be read.
    int         m_wait [32];
    logic [1:0] m_ex_valid;
    pc_set_t    m_ex_a, m_ex_b;
    logic [1:0] m_k;

    function automatic logic m_is_load(input pc_set_t s);
        return s.inst_type == T_MEM && !s.mem_we && s.rf_we && s.rf_rd != 0;
    endfunction

    function automatic logic m_blocked(input logic [4:0] r);
        return r != 0 && m_wait[r] > 0;
    endfunction

    function automatic logic [1:0] m_count();
        logic ok_b;
        if (rst || flush_BR || stall_DCache || !i_is_valid[1]) return 2'd0;
        if (m_blocked(set_a.rf_raddr1) || m_blocked(set_a.rf_raddr2)) return 2'd0;
        ok_b = i_is_valid[0] && !m_blocked(set_b.rf_raddr1) && !m_blocked(set_b.rf_raddr2);
        if (set_a.rf_we && set_a.rf_rd != 0 &&
            (set_b.rf_raddr1 == set_a.rf_rd || set_b.rf_raddr2 == set_a.rf_rd)) ok_b = 1'b0;
        if (set_a.rf_we && set_b.rf_we && set_a.rf_rd == set_b.rf_rd && set_a.rf_rd != 0) ok_b = 1'b0;
        if (set_a.inst_type == T_BR) ok_b = 1'b0;
        if (set_a.inst_type == T_MEM && set_b.inst_type == T_MEM) ok_b = 1'b0;
        if (set_a.inst_type == T_MDV && set_b.inst_type == T_MDV) ok_b = 1'b0;
        return ok_b ? 2'd2 : 2'd1;
    endfunction

    always @(posedge clk) begin
        m_k = m_count();
        if (rst) begin
            for (int r = 0; r < 32; r++) m_wait[r] = 0;
            m_ex_valid = 2'b00;
            m_ex_a = '0;
            m_ex_b = '0;
        end else if (flush_BR) begin
            for (int r = 0; r < 32; r++) m_wait[r] = 0;
            m_ex_valid = 2'b00;
        end else if (!stall_DCache) begin
            for (int r = 0; r < 32; r++) if (m_wait[r] > 0) m_wait[r] = m_wait[r] - 1;
            if (m_k >= 1 && m_is_load(set_a)) m_wait[set_a.rf_rd] = LOAD_LAT;
            else if (m_k == 2 && m_is_load(set_b)) m_wait[set_b.rf_rd] = LOAD_LAT;
            m_ex_valid = {m_k >= 1, m_k == 2};
            m_ex_a = set_a;
            m_ex_a.rf_rdata1 = a_rd1;
            m_ex_a.rf_rdata2 = a_rd2;
            m_ex_b = set_b;
            m_ex_b.rf_rdata1 = b_rd1;
            m_ex_b.rf_rdata2 = b_rd2;
        end
    end

    function automatic pc_set_t mk(input logic [4:0] ty, input logic we, input logic [4:0] rd,
                                   input logic [4:0] r1, input logic [4:0] r2, input logic mw);
        pc_set_t s;
        s.pc        = $urandom;
        s.imm       = $urandom;
        s.inst_type = ty;
        s.rf_we     = we;
        s.rf_rd     = rd;
        s.rf_raddr1 = r1;
        s.rf_raddr2 = r2;
        s.mem_we    = mw;
        s.rf_rdata1 = $urandom;
        s.rf_rdata2 = $urandom;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input pc_set_t a, input pc_set_t b, input logic [1:0] v);
        set_a      = a;
        set_b      = b;
        i_is_valid = v;
        a_rd1      = $urandom;
        a_rd2      = $urandom;
        b_rd1      = $urandom;
        b_rd2      = $urandom;
    endtask

    task automatic idle(input int n);
        flush_BR     = 1'b0;
        stall_DCache = 1'b0;
        drive(mk(T_ALU, 1, 1, 0, 0, 0), mk(T_ALU, 1, 2, 0, 0, 0), 2'b00);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush_BR = 1'b0;
        stall_DCache = 1'b0;
        drive(mk(T_ALU, 1, 4, 1, 2, 0), mk(T_ALU, 1, 5, 3, 3, 0), 2'b11);
        #2;
        n_cmp++; if (o_usingNUM !== 2'b00) begin n_bad++; $display("FAIL reset_num: got %b want 00", o_usingNUM); end
        tick();
        n_cmp++; if (o_ex_valid !== 2'b00) begin n_bad++; $display("FAIL reset_valid: got %b want 00", o_ex_valid); end
        n_cmp++; if (o_ex_set_a !== '0 || o_ex_set_b !== '0) begin n_bad++; $display("FAIL reset_sets: got %h / %h want 0", o_ex_set_a, o_ex_set_b); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_dual_issue();
        idle(3);
        drive(mk(T_ALU, 1, 4, 1, 2, 0), mk(T_ALU, 1, 5, 3, 3, 0), 2'b11);
        #2;
        n_cmp++; if (o_usingNUM !== 2'b10) begin n_bad++; $display("FAIL dual_num: got %b want 10", o_usingNUM); end
        tick();
        n_cmp++; if (o_ex_valid !== 2'b11) begin n_bad++; $display("FAIL dual_valid: got %b want 11", o_ex_valid); end
        n_cmp++; if (o_ex_set_a.rf_rdata1 !== a_rd1 || o_ex_set_a.rf_rdata2 !== a_rd2)
            begin n_bad++; $display("FAIL dual_a_rdata: got %h %h want %h %h", o_ex_set_a.rf_rdata1, o_ex_set_a.rf_rdata2, a_rd1, a_rd2); end
        n_cmp++; if (o_ex_set_b.rf_rdata1 !== b_rd1 || o_ex_set_b.rf_rdata2 !== b_rd2 || o_ex_set_b.rf_rd !== 5'd5)
            begin n_bad++; $display("FAIL dual_b: got %h %h rd %0d want %h %h rd 5", o_ex_set_b.rf_rdata1, o_ex_set_b.rf_rdata2, o_ex_set_b.rf_rd, b_rd1, b_rd2); end
    endtask

    task automatic test_raw();
        idle(3);
        drive(mk(T_ALU, 1, 4, 1, 2, 0), mk(T_ALU, 1, 6, 4, 1, 0), 2'b11);
        #2;
        n_cmp++; if (o_usingNUM !== 2'b01) begin n_bad++; $display("FAIL raw_num: got %b want 01", o_usingNUM); end
        tick();
        n_cmp++; if (o_ex_valid !== 2'b10) begin n_bad++; $display("FAIL raw_valid: got %b want 10", o_ex_valid); end
        drive(mk(T_ALU, 1, 0, 1, 2, 0), mk(T_ALU, 1, 6, 0, 3, 0), 2'b11);
        #2;
        n_cmp++; if (o_usingNUM !== 2'b10) begin n_bad++; $display("FAIL raw_r0_num: got %b want 10", o_usingNUM); end
        tick();
    endtask

    task automatic test_load_use();
        idle(3);
        drive(mk(T_MEM, 1, 7, 1, 0, 0), mk(T_ALU, 1, 9, 7, 2, 0), 2'b10);
        #2;
        n_cmp++; if (o_usingNUM !== 2'b01) begin n_bad++; $display("FAIL lu_ld_num: got %b want 01", o_usingNUM); end
        tick();
        drive(mk(T_ALU, 1, 8, 7, 1, 0), mk(T_ALU, 1, 9, 2, 2, 0), 2'b10);
        #2;
        n_cmp++; if (o_usingNUM !== 2'b00) begin n_bad++; $display("FAIL lu_n1: got %b want 00", o_usingNUM); end
        tick();
        n_cmp++; if (o_ex_valid !== 2'b00) begin n_bad++; $display("FAIL lu_bubble: got %b want 00", o_ex_valid); end
        #1;
        n_cmp++; if (o_usingNUM !== 2'b00) begin n_bad++; $display("FAIL lu_n2: got %b want 00", o_usingNUM); end
        tick();
        #1;
        n_cmp++; if (o_usingNUM !== 2'b01) begin n_bad++; $display("FAIL lu_n3: got %b want 01", o_usingNUM); end
        tick();
        n_cmp++; if (o_ex_valid !== 2'b10 || o_ex_set_a.rf_rd !== 5'd8)
            begin n_bad++; $display("FAIL lu_ex: got %b rd %0d want 10 rd 8", o_ex_valid, o_ex_set_a.rf_rd); end
    endtask

    task automatic test_structural();
        pc_set_t pa [3];
        pc_set_t pb [3];
        idle(3);
        pa[0] = mk(T_MEM, 1, 9, 1, 0, 0);  pb[0] = mk(T_MEM, 0, 0, 2, 3, 1);
        pa[1] = mk(T_MDV, 1, 10, 1, 2, 0); pb[1] = mk(T_MDV, 1, 11, 3, 4, 0);
        pa[2] = mk(T_BR, 0, 0, 1, 2, 0);   pb[2] = mk(T_ALU, 1, 12, 5, 6, 0);
        for (int i = 0; i < 3; i++) begin
            drive(pa[i], pb[i], 2'b11);
            #2;
            n_cmp++; if (o_usingNUM !== 2'b01) begin n_bad++; $display("FAIL struct_num[%0d]: got %b want 01", i, o_usingNUM); end
            tick();
            n_cmp++; if (o_ex_valid !== 2'b10) begin n_bad++; $display("FAIL struct_valid[%0d]: got %b want 10", i, o_ex_valid); end
        end
    endtask

    task automatic test_stall();
        idle(3);
        drive(mk(T_MEM, 1, 7, 1, 0, 0), mk(T_ALU, 1, 9, 7, 2, 0), 2'b10);
        tick();
        stall_DCache = 1'b1;
        drive(mk(T_ALU, 1, 4, 1, 2, 0), mk(T_ALU, 1, 5, 3, 3, 0), 2'b11);
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++; if (o_usingNUM !== 2'b00) begin n_bad++; $display("FAIL stall_num[%0d]: got %b want 00", i, o_usingNUM); end
            tick();
            n_cmp++; if (o_ex_valid !== 2'b10 || o_ex_set_a.rf_rd !== 5'd7 || o_ex_set_a.inst_type !== T_MEM)
                begin n_bad++; $display("FAIL stall_hold[%0d]: got %b rd %0d type %0d want 10 rd 7 type 3", i, o_ex_valid, o_ex_set_a.rf_rd, o_ex_set_a.inst_type); end
        end
        stall_DCache = 1'b0;
        drive(mk(T_ALU, 1, 8, 7, 1, 0), mk(T_ALU, 1, 5, 3, 3, 0), 2'b11);
        #2;
        n_cmp++; if (o_usingNUM !== 2'b00) begin n_bad++; $display("FAIL stall_cnt_hold: got %b want 00", o_usingNUM); end
        tick();
        #1;
        n_cmp++; if (o_usingNUM !== 2'b00) begin n_bad++; $display("FAIL stall_cnt_dec: got %b want 00", o_usingNUM); end
        tick();
        #1;
        n_cmp++; if (o_usingNUM !== 2'b10) begin n_bad++; $display("FAIL stall_resume: got %b want 10", o_usingNUM); end
        tick();
        n_cmp++; if (o_ex_valid !== 2'b11) begin n_bad++; $display("FAIL stall_resume_ex: got %b want 11", o_ex_valid); end
    endtask

    task automatic test_flush();
        idle(3);
        drive(mk(T_MEM, 1, 7, 1, 0, 0), mk(T_ALU, 1, 5, 3, 3, 0), 2'b11);
        #2;
        n_cmp++; if (o_usingNUM !== 2'b10) begin n_bad++; $display("FAIL flush_setup_num: got %b want 10", o_usingNUM); end
        tick();
        flush_BR = 1'b1;
        #2;
        n_cmp++; if (o_usingNUM !== 2'b00) begin n_bad++; $display("FAIL flush_num: got %b want 00", o_usingNUM); end
        tick();
        n_cmp++; if (o_ex_valid !== 2'b00) begin n_bad++; $display("FAIL flush_valid: got %b want 00", o_ex_valid); end
        flush_BR = 1'b0;
        drive(mk(T_ALU, 1, 8, 7, 1, 0), mk(T_ALU, 1, 5, 3, 3, 0), 2'b10);
        #2;
        n_cmp++; if (o_usingNUM !== 2'b01) begin n_bad++; $display("FAIL flush_cnt_clear: got %b want 01", o_usingNUM); end
        tick();
        flush_BR = 1'b1;
        stall_DCache = 1'b1;
        drive(mk(T_ALU, 1, 4, 1, 2, 0), mk(T_ALU, 1, 5, 3, 3, 0), 2'b11);
        tick();
        n_cmp++; if (o_ex_valid !== 2'b00) begin n_bad++; $display("FAIL flush_over_stall: got %b want 00", o_ex_valid); end
        flush_BR = 1'b0;
        stall_DCache = 1'b0;
        tick();
        stall_DCache = 1'b1;
        rst = 1'b1;
        tick();
        n_cmp++; if (o_ex_valid !== 2'b00 || o_ex_set_a !== '0)
            begin n_bad++; $display("FAIL rst_over_stall: got %b a=%h want 00 a=0", o_ex_valid, o_ex_set_a); end
        rst = 1'b0;
        stall_DCache = 1'b0;
    endtask

    task automatic test_random();
        pc_set_t a, b;
        logic [1:0] want;
        idle(2);
        for (int c = 0; c < 600; c++) begin
            a = mk(5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            b = mk(5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            drive(a, b, 2'($urandom_range(0, 3)));
            flush_BR     = ($urandom_range(0, 99) < 3);
            stall_DCache = ($urandom_range(0, 99) < 12);
            rst          = ($urandom_range(0, 199) == 0);
            #2;
            want = m_count();
            n_cmp++; if (o_usingNUM !== want) begin n_bad++; $display("FAIL rnd_num[%0d]: got %b want %b", c, o_usingNUM, want); end
            tick();
            n_cmp++; if (o_ex_valid !== m_ex_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, o_ex_valid, m_ex_valid); end
            if (m_ex_valid[1]) begin
                n_cmp++; if (o_ex_set_a !== m_ex_a) begin n_bad++; $display("FAIL rnd_ex_a[%0d]: got %h want %h", c, o_ex_set_a, m_ex_a); end
            end
            if (m_ex_valid[0]) begin
                n_cmp++; if (o_ex_set_b !== m_ex_b) begin n_bad++; $display("FAIL rnd_ex_b[%0d]: got %h want %h", c, o_ex_set_b, m_ex_b); end
            end
        end
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dual_issue();
        test_raw();
        test_load_use();
        test_structural();
        test_stall();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
